// File: rtl/spi_frame_tx.sv
// SPI master that streams one snapshotted display page plus size, cursor and answer bytes.
// Optional CRC-8 trailer byte: define SPI_FRAME_CRC_EN.
module spi_frame_tx #(
  parameter int DEPTH     = 32,
  parameter int PAGE      = 16,
  parameter int WIDTH     = 8,
  parameter int ANS_W     = 44,
  parameter int CLK_DIV   = 49,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int AUTO      = 1,
  parameter int GAP_TICKS = 200,
  localparam int NPAGE    = DEPTH / PAGE,
  localparam int PW       = (NPAGE > 1) ? $clog2(NPAGE) : 1,
  localparam int SW       = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     jump,
  input  logic                     start,
  input  logic [DEPTH*WIDTH-1:0]   mem_flat,
  input  logic [SW-1:0]            size_in,
  input  logic [SW-1:0]            ptr_in,
  input  logic [ANS_W-1:0]         answer,
  output logic                     busy,
  output logic                     frame_done,
  output logic [PW-1:0]            page_idx,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     cs,
  output logic [2:0]               dbg_state
);

  localparam int ANS_BYTES = (ANS_W + PW + 7) / 8;
  localparam int ANS_BITS  = 8 * ANS_BYTES;
  localparam int DATA_BITS = PAGE * WIDTH + 16 + ANS_BITS;
`ifdef SPI_FRAME_CRC_EN
  localparam int CRC_BITS  = 8;
`else
  localparam int CRC_BITS  = 0;
`endif
  localparam int FRAME_BITS = DATA_BITS + CRC_BITS;
  localparam int BW = $clog2(FRAME_BITS);
  localparam int CW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic POL = (CPOL != 0);

  if (SW > 8 || (DEPTH % PAGE) != 0) begin : g_param_check
    $error("spi_frame_tx: clog2(DEPTH+1) must be <= 8 and DEPTH a multiple of PAGE");
  end

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                state;
  logic [CW-1:0]         div_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] sr_next;
  logic [FRAME_BITS-1:0] snap;
  logic [ANS_BITS-1:0]   ans_field;
  logic                  jump_q;
  logic                  tick;
  logic                  shift_evt;

  assign dbg_state = state;
  assign tick      = (div_cnt == CW'(CLK_DIV));
  // The edge that launches a bit: trailing for CPHA=0, leading for CPHA=1.
  assign shift_evt = (state == SHIFT) && tick &&
                     ((CPHA == 0) ? (sclk != POL) : (sclk == POL));

  always_comb begin
    ans_field = '0;
    ans_field[ANS_W-1:0] = answer;
    ans_field[ANS_W +: PW] = page_idx;
    snap = '0;
    for (int j = 0; j < PAGE; j++) begin
      snap[FRAME_BITS-1-j*WIDTH -: WIDTH] = mem_flat[(int'(page_idx)*PAGE + j)*WIDTH +: WIDTH];
    end
    snap[FRAME_BITS-1-PAGE*WIDTH -: 8] = 8'(size_in);
    snap[FRAME_BITS-9-PAGE*WIDTH -: 8] = 8'(ptr_in);
    snap[CRC_BITS +: ANS_BITS] = ans_field;
  end

`ifdef SPI_FRAME_CRC_EN
  logic [7:0] crc;
  logic [7:0] crc_next;

  always_comb begin
    crc_next = {crc[6:0], 1'b0} ^ ((crc[7] ^ sr[FRAME_BITS-1]) ? 8'h07 : 8'h00);
    // When the last data bit leaves, the trailer byte takes its place at the top.
    sr_next  = (bit_cnt == BW'(8)) ? {crc_next, {(FRAME_BITS-8){1'b0}}} : (sr << 1);
  end

  always_ff @(posedge clock) begin
    if (reset || state == IDLE) crc <= 8'h00;
    else if (shift_evt && bit_cnt >= BW'(8)) crc <= crc_next;
  end
`else
  always_comb sr_next = sr << 1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cs         <= 1'b1;
      sclk       <= POL;
      mosi       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      page_idx   <= '0;
      jump_q     <= 1'b0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
    end else begin
      jump_q     <= jump;
      frame_done <= 1'b0;
      if (jump && !jump_q)
        page_idx <= (page_idx == PW'(NPAGE-1)) ? '0 : page_idx + 1'b1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;

      case (state)
        IDLE: begin
          div_cnt <= '0;
          if ((AUTO != 0) || start) begin
            sr      <= snap;
            busy    <= 1'b1;
            cs      <= 1'b0;
            sclk    <= POL;
            mosi    <= (CPHA == 0) ? snap[FRAME_BITS-1] : 1'b0;
            bit_cnt <= BW'(FRAME_BITS-1);
            state   <= SETUP;
          end
        end
        SETUP: if (tick) state <= SHIFT;
        SHIFT: if (tick) begin
          sclk <= ~sclk;
          if (shift_evt) begin
            sr   <= sr_next;
            mosi <= (CPHA == 0) ? sr_next[FRAME_BITS-1] : sr[FRAME_BITS-1];
          end
          if (sclk != POL) begin
            if (bit_cnt == '0) state <= HOLD;
            else bit_cnt <= bit_cnt - 1'b1;
          end
        end
        HOLD: if (tick) begin
          cs         <= 1'b1;
          mosi       <= 1'b0;
          frame_done <= 1'b1;
          busy       <= 1'b0;
          gap_cnt    <= '0;
          state      <= GAP;
        end
        GAP: if (tick) begin
          if (int'(gap_cnt) + 1 >= GAP_TICKS) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: a mode-0 free-running unit and a mode-3 start/busy unit.
module tb_spi_frame_tx;
  localparam int DEPTH = 32, PAGE = 16, WIDTH = 8, ANS_W = 44, SW = 6, PW = 1;
`ifdef SPI_FRAME_CRC_EN
  localparam int FB = 200;
`else
  localparam int FB = 192;
`endif

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset0, reset3, jump0, jump3, start0, start3;
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic [SW-1:0]          size_in, ptr_in;
  logic [ANS_W-1:0]       answer;
  logic [1:0]             busy, done, sclk, mosi, cs;
  logic [PW-1:0]          pg0, pg3;
  logic [2:0]             st0, st3;

  spi_frame_tx #(.DEPTH(DEPTH), .PAGE(PAGE), .WIDTH(WIDTH), .ANS_W(ANS_W), .CLK_DIV(1),
                 .CPOL(0), .CPHA(0), .AUTO(1), .GAP_TICKS(4)) dut0 (
    .clock(clock), .reset(reset0), .jump(jump0), .start(start0), .mem_flat(mem_flat),
    .size_in(size_in), .ptr_in(ptr_in), .answer(answer), .busy(busy[0]),
    .frame_done(done[0]), .page_idx(pg0), .sclk(sclk[0]), .mosi(mosi[0]), .cs(cs[0]),
    .dbg_state(st0));

  spi_frame_tx #(.DEPTH(DEPTH), .PAGE(PAGE), .WIDTH(WIDTH), .ANS_W(ANS_W), .CLK_DIV(1),
                 .CPOL(1), .CPHA(1), .AUTO(0), .GAP_TICKS(4)) dut3 (
    .clock(clock), .reset(reset3), .jump(jump3), .start(start3), .mem_flat(mem_flat),
    .size_in(size_in), .ptr_in(ptr_in), .answer(answer), .busy(busy[1]),
    .frame_done(done[1]), .page_idx(pg3), .sclk(sclk[1]), .mosi(mosi[1]), .cs(cs[1]),
    .dbg_state(st3));

  // frame monitor: sample mosi on every sclk rising edge while cs is low
  logic [FB-1:0] cur [2];
  logic [FB-1:0] frm [2][4];
  int   ncur [2] = '{0, 0};
  int   flen [2][4];
  int   nfrm [2] = '{0, 0};
  int   mosi_bad [2] = '{0, 0};
  logic [1:0] sclk_q = 2'b00, mosi_q = 2'b00, cs_q = 2'b11;

  always @(negedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (!cs_q[u] && !cs[u] && mosi[u] != mosi_q[u] && !(sclk_q[u] && !sclk[u]))
        mosi_bad[u]++;
      if (!cs[u] && sclk[u] && !sclk_q[u]) begin
        cur[u] = {cur[u][FB-2:0], mosi[u]};
        ncur[u]++;
      end
      if (done[u]) begin
        if (nfrm[u] < 4) begin
          frm[u][nfrm[u]]  = cur[u];
          flen[u][nfrm[u]] = ncur[u];
        end
        nfrm[u]++;
      end
      if (cs[u]) begin
        cur[u]  = '0;
        ncur[u] = 0;
      end
    end
    sclk_q = sclk;
    mosi_q = mosi;
    cs_q   = cs;
  end

  // scoreboard
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r = c;
    for (int i = 7; i >= 0; i--) r = {r[6:0], 1'b0} ^ ((r[7] ^ b[i]) ? 8'h07 : 8'h00);
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input int p, input int k);
    logic [7:0] tail [5] = '{8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    if (k < 16) return 8'(p * 16 + k);
    if (k == 16) return 8'h05;
    if (k == 17) return 8'h03;
    if (k == 18) return (p != 0) ? 8'h11 : 8'h01;
    return tail[k-19];
  endfunction

  // driver tasks
  task automatic wait_frames(input int u, input int n, input int budget);
    int c = 0;
    while (nfrm[u] < n && c < budget) begin
      @(negedge clock);
      c++;
    end
    chk($sformatf("wait_frame_u%0d_n%0d", u, n), 64'(nfrm[u] >= n), 64'd1);
  endtask

  task automatic pulse_start3();
    @(negedge clock) start3 = 1'b1;
    @(negedge clock) start3 = 1'b0;
  endtask

  task automatic pulse_jump(input int u);
    @(negedge clock);
    if (u == 0) jump0 = 1'b1; else jump3 = 1'b1;
    repeat (3) @(negedge clock);
    if (u == 0) jump0 = 1'b0; else jump3 = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  typedef struct {
    int         unit;
    int         fidx;
    int         pos;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [$];

  initial begin
    logic [FB-1:0] t;
    logic [7:0]    c;
    int            plan [4][3] = '{'{0, 0, 0}, '{0, 1, 1}, '{1, 0, 0}, '{1, 1, 0}};

    foreach (plan[i]) begin
      c = 8'h00;
      for (int k = 0; k < 24; k++) begin
        tbl.push_back('{plan[i][0], plan[i][1], k, exp_byte(plan[i][2], k)});
        c = crc_upd(c, exp_byte(plan[i][2], k));
      end
`ifdef SPI_FRAME_CRC_EN
      tbl.push_back('{plan[i][0], plan[i][1], 24, c});
`endif
    end

    reset0 = 1'b1; reset3 = 1'b1; jump0 = 1'b0; jump3 = 1'b0; start0 = 1'b0; start3 = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_flat[i*WIDTH +: WIDTH] = 8'(i);
    size_in = 6'd5; ptr_in = 6'd3; answer = 44'h123_4567_89AB;
    repeat (3) @(negedge clock);

    chk("rst0_cs", 64'(cs[0]), 64'd1);
    chk("rst0_sclk", 64'(sclk[0]), 64'd0);
    chk("rst0_mosi", 64'(mosi[0]), 64'd0);
    chk("rst0_busy", 64'(busy[0]), 64'd0);
    chk("rst0_done", 64'(done[0]), 64'd0);
    chk("rst3_sclk", 64'(sclk[1]), 64'd1);
    chk("rst3_pg", 64'(pg3), 64'd0);

    // mode 0, free running, page change mid-frame
    reset0 = 1'b0;
    @(negedge clock);
    chk("auto_busy", 64'(busy[0]), 64'd1);
    repeat (100) @(negedge clock);
    pulse_jump(0);
    chk("jump_pg1", 64'(pg0), 64'd1);
    wait_frames(0, 1, 3000);
    repeat (60) @(negedge clock);
    pulse_jump(0);
    chk("jump_wrap_pg0", 64'(pg0), 64'd0);
    wait_frames(0, 2, 3000);
    chk("mode0_mosi_edges", 64'(mosi_bad[0]), 64'd0);
    reset0 = 1'b1;

    // mode 3, start/busy handshake
    reset3 = 1'b0;
    repeat (20) @(negedge clock);
    chk("hs_idle_busy", 64'(busy[1]), 64'd0);
    chk("hs_idle_sclk", 64'(sclk[1]), 64'd1);
    chk("hs_idle_noframe", 64'(nfrm[1]), 64'd0);
    pulse_start3();
    chk("hs_busy_rise", 64'(busy[1]), 64'd1);
    repeat (40) @(negedge clock);
    pulse_start3();
    mem_flat[7:0] = 8'hFF; size_in = 6'd9;
    wait_frames(1, 1, 3000);
    mem_flat[7:0] = 8'h00; size_in = 6'd5;
    repeat (100) @(negedge clock);
    chk("hs_one_frame", 64'(nfrm[1]), 64'd1);
    chk("hs_busy_clear", 64'(busy[1]), 64'd0);
    pulse_start3();
    wait_frames(1, 2, 3000);
    chk("mode3_mosi_edges", 64'(mosi_bad[1]), 64'd0);

    // reset in the middle of SHIFT with CPOL=1
    pulse_jump(1);
    chk("hs_jump_pg1", 64'(pg3), 64'd1);
    pulse_start3();
    repeat (60) @(negedge clock);
    chk("pre_rst_shift", 64'(st3), 64'd2);
    reset3 = 1'b1;
    @(negedge clock);
    chk("midrst_cs", 64'(cs[1]), 64'd1);
    chk("midrst_sclk", 64'(sclk[1]), 64'd1);
    chk("midrst_mosi", 64'(mosi[1]), 64'd0);
    chk("midrst_busy", 64'(busy[1]), 64'd0);
    chk("midrst_pg", 64'(pg3), 64'd0);
    reset3 = 1'b0;
    repeat (5) @(negedge clock);

`ifdef SPI_FRAME_CRC_EN
    mem_flat = '0; size_in = '0; ptr_in = '0; answer = '0;
    pulse_start3();
    wait_frames(1, 3, 3000);
    t = frm[1][2];
    chk("crc_zero_len", 64'(flen[1][2]), 64'(FB));
    chk("crc_zero_trailer", 64'(t[7:0]), 64'h00);
    repeat (20) @(negedge clock);
    mem_flat[7:0] = 8'h80;
    c = crc_upd(8'h00, 8'h80);
    for (int k = 1; k < 24; k++) c = crc_upd(c, 8'h00);
    pulse_start3();
    wait_frames(1, 4, 3000);
    t = frm[1][3];
    chk("crc_m80_trailer", 64'(t[7:0]), 64'(c));
`endif
    chk("crc_model_01", 64'(crc_upd(8'h00, 8'h01)), 64'h07);

    // captured frames against the byte table
    for (int u = 0; u < 2; u++)
      for (int f = 0; f < 2; f++)
        chk($sformatf("len_u%0d_f%0d", u, f), 64'(flen[u][f]), 64'(FB));
    foreach (tbl[i]) begin
      t = frm[tbl[i].unit][tbl[i].fidx];
      chk($sformatf("byte_u%0d_f%0d_b%0d", tbl[i].unit, tbl[i].fidx, tbl[i].pos),
          64'(t[FB-1-8*tbl[i].pos -: 8]), 64'(tbl[i].exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- Parametrised SPI master that streams one display page of the entry buffer, followed by size, cursor pointer and answer, to the display MCU.
- Sits between the keyboard/evaluator core and the external display controller.
- Generalises the earlier fixed transmitter with:
  - any page size, page count, word width and answer width;
  - all four SPI modes;
  - a start/busy/done handshake or free-running operation;
  - a frame snapshot so the MCU never receives a torn frame.

Parameters:
- DEPTH, 32: entry buffer words.
- PAGE, 16: words per page; DEPTH must be a multiple of PAGE.
- WIDTH, 8: bits per buffer word.
- ANS_W, 44: answer width.
- CLK_DIV, 49: SCLK half-period is CLK_DIV+1 clock cycles.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- AUTO, 1: 1 = frames repeat automatically; 0 = one frame per start pulse.
- GAP_TICKS, 200: half-period ticks with cs high between frames.
- Derived (not overridable):
  - NPAGE = DEPTH/PAGE.
  - PW = max(1, clog2(NPAGE)).
  - ANS_BYTES = ceil((ANS_W+PW)/8).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jump  in  1  level; each rising edge advances the page
- start  in  1  frame request pulse, used when AUTO=0
- mem_flat  in  DEPTH*WIDTH  word i at [i*WIDTH +: WIDTH]
- size_in  in  clog2(DEPTH+1)  buffer fill count
- ptr_in  in  clog2(DEPTH+1)  cursor position
- answer  in  ANS_W  evaluator result
- busy  out  1  high from start acceptance until frame_done
- frame_done  out  1  one-cycle pulse when cs rises after the last bit
- page_idx  out  PW  page currently selected
- sclk  out  1  SPI clock
- mosi  out  1  SPI data, MSB first
- cs  out  1  active-low chip select

Behaviour:
- Reset values: cs=1, sclk=CPOL, mosi=0, busy=0, frame_done=0, page_idx=0, state=IDLE, all counters 0.
- Reset wins over everything and aborts any frame in progress; the next cycle shows the idle pins.
- Page select:
  - jump is edge-detected with a one-cycle registered history (reset to 0).
  - Each rising edge does page_idx <= page_idx+1, wrapping from NPAGE-1 to 0.
  - Works in any state. A frame always uses the page latched at its snapshot.
- Frame bytes, in order:
  - PAGE words of mem[page_idx*PAGE .. +PAGE-1], WIDTH bits each;
  - size_in zero-extended to 8 bits;
  - ptr_in zero-extended to 8 bits;
  - {zero pad, page_idx, answer} in ANS_BYTES*8 bits.
- Total FRAME_BITS = PAGE*WIDTH + 16 + 8*ANS_BYTES.
- Elaboration error if clog2(DEPTH+1) > 8.
- States:
  - IDLE: start is accepted when (AUTO=0 and start=1) or AUTO=1. On the accepting edge: snapshot the whole frame into a FRAME_BITS shift register, set busy=1, go to SETUP.
  - SETUP: cs=0 on the next cycle, sclk=CPOL. When CPHA=0, mosi = frame MSB. Stay one half-period, then go to SHIFT.
  - SHIFT: sclk toggles every half-period tick, giving exactly FRAME_BITS full SCLK cycles.
    - CPHA=0: mosi updates on each trailing edge.
    - CPHA=1: mosi updates on each leading edge.
    - A bit counter runs from FRAME_BITS-1 down to 0. After the final trailing edge, go to HOLD.
  - HOLD: one half-period with sclk=CPOL. Then cs=1, mosi=0, pulse frame_done, clear busy, go to GAP.
  - GAP: wait GAP_TICKS half-period ticks, then go to IDLE.
- start is ignored while busy or in GAP; there is no queuing.
- Inputs may change freely mid-frame; transmitted data is only what the snapshot captured.
- The half-period tick counter restarts at every state change.

Optional Feature:
- Macro: SPI_FRAME_CRC_EN.
- When defined:
  - an 8-bit CRC (poly 0x07, init 0x00, no reflection, no final XOR) is computed serially over every transmitted frame bit;
  - it is appended as one extra byte, MSB first, before HOLD;
  - FRAME_BITS grows by 8.
- When undefined: no CRC logic; the frame ends after the answer bytes.

Test Plan:
- Reset test: assert reset mid-SHIFT with CPOL=1 → next cycle cs=1, sclk=1, mosi=0, busy=0, page_idx=0.
- Mode 0 frame: set DEPTH=32, PAGE=16, CLK_DIV=1, mem[i]=i, size_in=5, ptr_in=3, answer=44'h123_4567_89AB, page 0.
  - Response: 192 rising edges, sampled bytes 00..0F, 05, 03, 01 23 45 67 89 AB, then one frame_done pulse.
- Page change: one jump pulse mid-frame.
  - Current frame is unchanged.
  - Next frame carries 10..1F, and its answer top byte is 0x11.
  - A second jump pulse wraps page_idx back to 0.
- Mode 3 (CPOL=1, CPHA=1), same data: sclk idles 1, mosi changes only on falling edges, and sampling on rising edges yields identical bytes.
- Handshake (AUTO=0):
  - start pulse → busy rises the next cycle.
  - A second start pulse while busy → ignored; exactly one frame is sent.
  - After GAP, a new start pulse → new frame.
- SPI_FRAME_CRC_EN defined:
  - All-zero inputs → 200 bits with trailer 0x00.
  - Setting only mem[0]=0x80 → trailer equals the bench CRC-8 model value.
  - Bench CRC-8 model check: a single byte 0x01 → 0x07.
